// File: rtl/ram_arbiter_pkg.sv
// Shared types, bus-width macros and the grant-selection helper for ram_arbiter.
// The bus macros mirror buceros_header.v; each is guarded so the shared header may be included first.
`ifndef MemAddrBus
`define MemAddrBus 31:0
`endif
`ifndef WordBus
`define WordBus 31:0
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0000_0000
`endif
`ifndef RamSelBus
`define RamSelBus 3:0
`endif
`ifndef ARB_STARVE_LIMIT_DEF
`define ARB_STARVE_LIMIT_DEF 4
`endif

package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LS   = 2'd2
    } gnt_sel_e;

    typedef struct packed {
        logic [`MemAddrBus] addr;
        logic               we;
        logic [`WordBus]    wdata;
        logic [`RamSelBus]  sel;
    } ls_req_t;

    // LS wins unless IF has been starved; a forced IF slot falls back to LS when IF is idle.
    function automatic gnt_sel_e arb_pick(input logic ls_req, input logic if_req,
                                          input logic force_if);
        gnt_sel_e sel;
        sel = GNT_NONE;
        if (ls_req && !force_if) sel = GNT_LS;
        else if (if_req)         sel = GNT_IF;
        else if (ls_req)         sel = GNT_LS;
        return sel;
    endfunction

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating starvation counter: counts IF-denied cycles, reports when the limit is reached.
import ram_arbiter_pkg::*;

module ram_arb_starve_ctr #(
    parameter int LIMIT = `ARB_STARVE_LIMIT_DEF,
    parameter int W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt < W'(LIMIT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sat = (r_cnt >= W'(LIMIT));

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter between instruction fetch and load/store, 1-cycle registered response.
// Optional RAM_ARB_STATS_EN adds conflict and forced-IF event counters.
import ram_arbiter_pkg::*;

module ram_arbiter #(
    parameter int STARVE_LIMIT = `ARB_STARVE_LIMIT_DEF,
    parameter int STARVE_CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req_i,
    input  logic [`MemAddrBus] if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [`WordBus]    if_rdata_o,
    input  logic               ls_req_i,
    input  logic [`MemAddrBus] ls_addr_i,
    input  logic               ls_we_i,
    input  logic [`WordBus]    ls_wdata_i,
    input  logic [`RamSelBus]  ls_sel_i,
    output logic               ls_gnt_o,
    output logic               ls_rvalid_o,
    output logic [`WordBus]    ls_rdata_o,
    output logic [`MemAddrBus] ram_addr_o,
    output logic               ram_w_en_o,
    output logic [`WordBus]    ram_w_data_o,
    output logic [`RamSelBus]  ram_w_sel_o,
    input  logic [`WordBus]    ram_r_data_i
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [31:0]        conflict_cnt_o,
    output logic [31:0]        starve_hit_cnt_o
`endif
);

    ls_req_t         w_ls;
    gnt_sel_e        w_sel;
    logic            w_force_if;
    logic            w_starve_inc;
    logic            r_if_rvalid;
    logic            r_ls_rvalid;
    logic [`WordBus] r_if_rdata;
    logic [`WordBus] r_ls_rdata;

    assign w_ls = '{addr: ls_addr_i, we: ls_we_i, wdata: ls_wdata_i, sel: ls_sel_i};

    always_comb begin
        w_sel        = rst ? GNT_NONE : arb_pick(ls_req_i, if_req_i, w_force_if);
        if_gnt_o     = (w_sel == GNT_IF);
        ls_gnt_o     = (w_sel == GNT_LS);
        ram_addr_o   = '0;
        ram_w_sel_o  = '0;
        ram_w_data_o = w_ls.wdata;
        ram_w_en_o   = ls_gnt_o & w_ls.we;
        case (w_sel)
            GNT_IF: begin
                ram_addr_o  = if_addr_i;
                ram_w_sel_o = w_ls.sel;
            end
            GNT_LS: begin
                ram_addr_o  = w_ls.addr;
                ram_w_sel_o = w_ls.sel;
            end
            default: ;
        endcase
    end

    // Any cycle IF is not waiting (granted or idle) resets its starvation history.
    assign w_starve_inc = if_req_i & ~if_gnt_o;

    ram_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT),
        .W     (STARVE_CNT_W)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_starve_inc),
        .i_clr (~w_starve_inc),
        .o_sat (w_force_if)
    );

    // Read data is sampled at the grant edge, so a write returns pre-write contents internally
    // but reports zero to LS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= `ZERO_WORD;
            r_ls_rdata  <= `ZERO_WORD;
        end else begin
            r_if_rvalid <= if_gnt_o;
            r_ls_rvalid <= ls_gnt_o;
            if (if_gnt_o) r_if_rdata <= ram_r_data_i;
            if (ls_gnt_o) r_ls_rdata <= w_ls.we ? `ZERO_WORD : ram_r_data_i;
        end
    end

    assign if_rvalid_o = r_if_rvalid;
    assign ls_rvalid_o = r_ls_rvalid;
    assign if_rdata_o  = r_if_rdata;
    assign ls_rdata_o  = r_ls_rdata;

`ifdef RAM_ARB_STATS_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_starve_hit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt   <= '0;
            r_starve_hit_cnt <= '0;
        end else begin
            if (if_req_i && ls_req_i)
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            if (w_force_if && if_gnt_o && ls_req_i)
                r_starve_hit_cnt <= r_starve_hit_cnt + 32'd1;
        end
    end

    assign conflict_cnt_o   = r_conflict_cnt;
    assign starve_hit_cnt_o = r_starve_hit_cnt;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: behavioural RAM, grant model and queued response expectations.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic [3:0]  ls_sel = '0;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_w_en;
    logic [31:0] if_rdata, ls_rdata, ram_addr, ram_w_data, ram_r_data;
    logic [3:0]  ram_w_sel;
`ifdef RAM_ARB_STATS_EN
    logic [31:0] conflict_cnt, starve_hit_cnt;
`endif

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_we_i(ls_we),
        .ls_wdata_i(ls_wdata), .ls_sel_i(ls_sel), .ls_gnt_o(ls_gnt),
        .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
        .ram_addr_o(ram_addr), .ram_w_en_o(ram_w_en), .ram_w_data_o(ram_w_data),
        .ram_w_sel_o(ram_w_sel), .ram_r_data_i(ram_r_data)
`ifdef RAM_ARB_STATS_EN
        , .conflict_cnt_o(conflict_cnt), .starve_hit_cnt_o(starve_hit_cnt)
`endif
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        if (i == 8) return 32'h1122_3344;
        return 32'h5000_0000 + i * 32'h0001_0101;
    endfunction

    // Behavioural RAM: combinational read, byte-selected write at the clock edge.
    logic [31:0] ram_mem [256];
    bit          ram_init = 1'b0;
    assign ram_r_data = ram_mem[ram_addr[9:2]];

    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
            ram_init <= 1'b1;
        end else if (ram_w_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_w_sel[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_w_data[8*b +: 8];
        end
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    typedef struct {
        bit          ls;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] ref_mem [256];
    bit          ref_init = 1'b0;
    int          mcnt = 0;

    // Monitor: retire last cycle's expectation, then predict this cycle's grant and response.
    always @(negedge clk) begin
        exp_t e;
        bit   force_if, eif, els;
        int   idx;
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rvalid_if", {31'd0, if_rvalid}, {31'd0, !e.ls});
            chk("rvalid_ls", {31'd0, ls_rvalid}, {31'd0, e.ls});
            chk(e.ls ? "rdata_ls" : "rdata_if", e.ls ? ls_rdata : if_rdata, e.data);
        end else begin
            chk("rvalid_idle", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        end
        eif = 1'b0;
        els = 1'b0;
        if (!rst) begin
            force_if = (mcnt >= 4);
            if (ls_req && !force_if) els = 1'b1;
            else if (if_req)         eif = 1'b1;
            else if (ls_req)         els = 1'b1;
        end
        chk("gnt", {30'd0, if_gnt, ls_gnt}, {30'd0, eif, els});
        if (rst) begin
            chk("wen_rst", {31'd0, ram_w_en}, 32'd0);
            mcnt = 0;
        end else begin
            if (eif) begin
                e.ls = 1'b0;
                e.data = ref_mem[if_addr[9:2]];
                q.push_back(e);
            end
            if (els) begin
                idx = int'(ls_addr[9:2]);
                e.ls = 1'b1;
                e.data = ls_we ? 32'd0 : ref_mem[idx];
                q.push_back(e);
                if (ls_we)
                    for (int b = 0; b < 4; b++)
                        if (ls_sel[b]) ref_mem[idx][8*b +: 8] = ls_wdata[8*b +: 8];
            end
            if (if_req && !eif) mcnt = (mcnt < 4) ? mcnt + 1 : 4;
            else                mcnt = 0;
        end
    end

    // One bus cycle: drive just after the edge, return at the following falling edge.
    task automatic cyc(input bit r, input bit ifr, input logic [31:0] ifa, input bit lsr,
                       input logic [31:0] lsa, input bit we, input logic [31:0] wd,
                       input logic [3:0] sel);
        @(posedge clk);
        #1;
        rst = r; if_req = ifr; if_addr = ifa;
        ls_req = lsr; ls_addr = lsa; ls_we = we; ls_wdata = wd; ls_sel = sel;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 0, 32'h0, 1, 32'hFFFF_FFFF, 4'hF);
    endtask

    logic [5:0] pat;

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rst_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);

        cyc(0, 1, 32'h10, 0, 0, 0, 0, 0);
        chk("if_only_gnt", {31'd0, if_gnt}, 32'd1);
        chk("if_only_addr", ram_addr, 32'h10);
        idle();
        chk("if_only_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("idle_wen", {31'd0, ram_w_en}, 32'd0);
        chk("idle_sel", {28'd0, ram_w_sel}, 32'd0);
        chk("idle_addr", ram_addr, 32'd0);

        cyc(0, 0, 0, 1, 32'h20, 1, 32'hA5A5_A5A5, 4'b0011);
        chk("wr_wen", {31'd0, ram_w_en}, 32'd1);
        chk("wr_sel", {28'd0, ram_w_sel}, 32'h3);
        chk("wr_addr", ram_addr, 32'h20);
        cyc(0, 0, 0, 1, 32'h20, 0, 0, 4'hF);
        chk("wr_ack_rdata", ls_rdata, 32'd0);
        idle();
        chk("rd_after_wr", ls_rdata, 32'h1122_A5A5);

        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 32'h10, 1, 32'h20, 0, 0, 4'hF);
            pat[i] = if_gnt;
            if (i == 5) chk("cont_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        end
        chk("cont_pattern", {26'd0, pat}, 32'b01_0000);
        idle();
`ifdef RAM_ARB_STATS_EN
        chk("conflict_cnt", conflict_cnt, 32'd6);
        chk("starve_hit_cnt", starve_hit_cnt, 32'd1);
`endif

        cyc(0, 1, 32'h10, 0, 0, 0, 0, 0);
        cyc(1, 1, 32'h10, 1, 32'h20, 1, 32'h1234_5678, 4'hF);
        chk("rst_mid_gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
        chk("rst_mid_wen", {31'd0, ram_w_en}, 32'd0);
        idle();
        chk("rst_mid_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
        chk("rst_mid_if_rdata", if_rdata, 32'd0);
        chk("rst_mid_ls_rdata", ls_rdata, 32'd0);

        cyc(0, 1, 32'h10, 1, 32'h20, 0, 0, 4'hF);
        cyc(0, 0, 32'h10, 1, 32'h20, 0, 0, 4'hF);
        chk("drop_no_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 32'h10, 1, 32'h24, 0, 0, 4'hF);
            pat[i] = if_gnt;
        end
        chk("drop_cnt_cleared", {26'd0, pat}, 32'b00_0000 | 32'b1_0000);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
